// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative inverse cipher.
// Holds the forward and inverse S-boxes, the key-schedule round constants,
// the GF(2^8) helpers, the word/state types and the control FSM encoding.
// Byte 0 of a state or word occupies its most significant byte.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [2:0] {NOKEY, KEYEXP, IDLE, ROUND, DONE} fsm_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t o;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = INV_SBOX[s[127-8*k -: 8]];
        return o;
    endfunction

    // Byte 4c+r is row r of column c; row r rotates right by r columns.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round.
//   state      : round input
//   rk         : round key for this round
//   last       : final round, InvMixColumns skipped
//   next_state : round output
module aes_inv_round
    import aes_pkg::*;
(
    input  state_t state,
    input  state_t rk,
    input  logic   last,
    output state_t next_state
);

    state_t t;

    always_comb begin
        t          = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
        next_state = last ? t : inv_mix_columns(t);
    end

endmodule

// File: rtl/aes_decipher_iter.sv
// Iterative AES inverse cipher (AES-128/192/256 chosen by KEY_BITS).
// The key is expanded into an on-chip round-key store one word per cycle,
// then each block runs one inverse round per clock on a shared datapath.
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   key/key_valid/key_ready  : cipher key load handshake
//   datain/in_valid/in_ready : ciphertext input handshake
//   dataout/out_valid/out_ready : plaintext output handshake
// Build option: define AES_DEC_2ROUND_EN to evaluate two rounds per clock.
module aes_decipher_iter
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_BITS-1:0] key,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [127:0]        datain,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [127:0]        dataout,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * NR + 4;
    localparam int KW = $clog2(NW);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_decipher_iter: KEY_BITS must be 128, 192 or 256");
    end

    fsm_t            fsm;
    state_t          st;
    logic [3:0]      cnt;
    logic [KW-1:0]   kidx;   // index of the schedule word being generated
    logic [2:0]      kmod;   // kidx mod NK
    logic [3:0]      rc;     // next RCON entry
    logic            in_rdy;
    word_t           w [NW]; // round-key store, valid only after KEYEXP
    word_t           tmp, wnew;
    state_t          nxt;
    logic            fin;
    logic            key_fire, in_fire;

    // A key offered in IDLE wins over data in the same cycle.
    assign in_ready = in_rdy & ~key_valid;
    assign key_fire = key_valid & key_ready;
    assign in_fire  = in_valid & in_ready;

    function automatic state_t rk_at(input logic [3:0] r);
        logic [KW-1:0] b;
        b = KW'({r, 2'b00});
        return {w[b], w[b + KW'(1)], w[b + KW'(2)], w[b + KW'(3)]};
    endfunction

    always_comb begin
        tmp = w[kidx - 1'b1];
        if (kmod == 3'd0)
            tmp = sub_word(rot_word(tmp)) ^ {RCON[rc], 24'h000000};
        else if (NK == 8 && kmod == 3'd4)
            tmp = sub_word(tmp);
        wnew = w[kidx - KW'(NK)] ^ tmp;
    end

`ifdef AES_DEC_2ROUND_EN
    localparam logic [3:0] CNT_STEP = 4'd2;
    state_t mid;
    // cnt starts odd, so the first round is never the last one.
    aes_inv_round u_rnd0 (.state(st),  .rk(rk_at(cnt)),        .last(1'b0),        .next_state(mid));
    aes_inv_round u_rnd1 (.state(mid), .rk(rk_at(cnt - 4'd1)), .last(cnt == 4'd1), .next_state(nxt));
    assign fin = (cnt == 4'd1);
`else
    localparam logic [3:0] CNT_STEP = 4'd1;
    aes_inv_round u_rnd0 (.state(st), .rk(rk_at(cnt)), .last(cnt == 4'd0), .next_state(nxt));
    assign fin = (cnt == 4'd0);
`endif

    // Round-key store carries no reset; KEYEXP always rewrites it before use.
    always_ff @(posedge clk) begin
        if (key_fire) begin
            for (int k = 0; k < NK; k++) w[KW'(k)] <= key[KEY_BITS-1-32*k -: 32];
        end else if (fsm == KEYEXP) begin
            w[kidx] <= wnew;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= NOKEY;
            key_ready <= 1'b1;
            in_rdy    <= 1'b0;
            out_valid <= 1'b0;
            dataout   <= '0;
            st        <= '0;
            cnt       <= '0;
            kidx      <= '0;
            kmod      <= '0;
            rc        <= '0;
        end else if (key_fire) begin
            fsm       <= KEYEXP;
            key_ready <= 1'b0;
            in_rdy    <= 1'b0;
            kidx      <= KW'(NK);
            kmod      <= '0;
            rc        <= '0;
        end else begin
            case (fsm)
                NOKEY: ;
                KEYEXP: begin
                    kidx <= kidx + 1'b1;
                    kmod <= (kmod == 3'(NK - 1)) ? 3'd0 : kmod + 3'd1;
                    if (kmod == 3'd0) rc <= rc + 4'd1;
                    if (kidx == KW'(NW - 1)) begin
                        fsm       <= IDLE;
                        key_ready <= 1'b1;
                        in_rdy    <= 1'b1;
                    end
                end
                IDLE: begin
                    if (in_fire) begin
                        st        <= datain ^ rk_at(4'(NR));
                        cnt       <= 4'(NR - 1);
                        fsm       <= ROUND;
                        key_ready <= 1'b0;
                        in_rdy    <= 1'b0;
                    end
                end
                ROUND: begin
                    st  <= nxt;
                    cnt <= cnt - CNT_STEP;
                    if (fin) begin
                        dataout   <= nxt;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= IDLE;
                        key_ready <= 1'b1;
                        in_rdy    <= 1'b1;
                    end
                end
                default: fsm <= NOKEY;
            endcase
        end
    end

endmodule

// File: doc/aes_decipher_iter.md
Name: aes_decipher_iter

Overview:
- Iterative, parameterised AES inverse cipher for AES-128, AES-192 or AES-256, selected at elaboration.
- Computes one inverse round per clock on a single shared datapath, replacing the fully unrolled 14-stage AES-256 decipher in area-constrained builds.
- Expands the cipher key on-chip into a round-key store once per key load.
- Uses valid/ready handshakes on the key, ciphertext and plaintext interfaces.

Parameters:
- KEY_BITS, 256, cipher key length; legal values are 128, 192 and 256. Any other value is an elaboration error.
- NK, KEY_BITS/32, key length in words (derived, localparam).
- NR, NK+6, number of rounds (derived, localparam).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- key  in  KEY_BITS  cipher key, FIPS-197 byte order (MSB = byte 0)
- key_valid  in  1  key offered
- key_ready  out  1  block accepts a new key
- datain  in  128  ciphertext block
- in_valid  in  1  ciphertext offered
- in_ready  out  1  block accepts ciphertext
- dataout  out  128  plaintext block
- out_valid  out  1  plaintext valid
- out_ready  in  1  consumer accepts plaintext

Behaviour:
- Reset and clock: one clock domain. Reset is asynchronous and active-low.
- Reset values: state=NOKEY, key_ready=1, in_ready=0, out_valid=0, dataout=0, round counter=0. The round-key store is not reset and is treated as invalid.
- FSM NOKEY:
  - key_ready=1.
  - key_valid&key_ready: write words w[0..NK-1] from key, then go to KEYEXP.
- FSM KEYEXP:
  - Generates one word w[i] per cycle for i=NK..4*NR+3, following the FIPS-197 schedule (RotWord/SubWord/Rcon when i%NK==0; SubWord only when NK==8 and i%8==4).
  - Takes 4*NR+4-NK cycles: 52, 46 and 40 for AES-256, -192 and -128.
  - key_ready=0 and in_ready=0 throughout.
  - Then go to IDLE.
- FSM IDLE:
  - in_ready=1 and key_ready=1.
  - A key handshake takes priority over a data handshake. If both occur in the same cycle, in_ready is forced low that cycle, the key is taken, and datain is not consumed.
  - in_valid&in_ready: state register <= datain ^ rk[NR], round counter <= NR-1, go to ROUND.
- FSM ROUND:
  - Each cycle: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[cnt]), then cnt <= cnt-1.
  - When cnt==0, the last round omits InvMixColumns. dataout is loaded, out_valid=1, go to DONE.
  - key_ready=0 and in_ready=0 throughout.
- FSM DONE:
  - out_valid held high and dataout held stable until out_ready.
  - On the handshake: out_valid=0 and go to IDLE. The next in_ready comes one cycle after the out handshake (no bypass).
- Latency: out_valid rises NR cycles after the accepting edge (14, 12 and 10).
- Throughput: one block per NR+2 cycles.
- rk[r]: words w[4r..4r+3]; w[4r] occupies bits 127:96.
- Key changes are accepted only in NOKEY or IDLE. key_valid in any other state is held off by key_ready=0 and never corrupts the store.
- Reset asserted mid-KEYEXP or mid-ROUND: immediate return to NOKEY. A fresh key load is required before any data is accepted.

Optional Feature:
- Macro: AES_DEC_2ROUND_EN.
- Defined:
  - Two inverse rounds are instantiated back-to-back, and cnt decrements by 2 per cycle.
  - The second instance takes the final-round form when its key index is 0.
  - Latency becomes NR/2 cycles (7, 6 and 5). Throughput is one block per NR/2+2 cycles.
  - KEYEXP timing and all handshakes are unchanged.
- Undefined: one round per cycle as described above.

Decomposition:
- Shared package aes_pkg contains:
  - SBOX and INV_SBOX constant arrays (256x8).
  - RCON array (10x8).
  - Functions xtime, gmul, sub_word, rot_word, inv_shift_rows and inv_mix_columns.
  - A typedef for the 128-bit state and the 32-bit word.
  - The FSM state enum (NOKEY, KEYEXP, IDLE, ROUND, DONE).
- Sub-module aes_inv_round: combinational, with inputs state, rk and last; output next state. It is instantiated once, or twice under AES_DEC_2ROUND_EN.

Test Plan:
- KEY_BITS=256, FIPS-197 C.3:
  - Stimulus: key 000102..1e1f, then datain 8ea2b7ca516745bfeafc49904b496089.
  - Required: dataout 00112233445566778899aabbccddeeff; out_valid exactly 14 cycles after the accepting edge; key_ready low for 52 cycles after the key load.
- KEY_BITS=128, C.1: key 000102..0e0f, datain 69c4e0d86a7b0430d8cdb78070b4c55a -> dataout 00112233..eeff, latency 10. KEY_BITS=192, C.2: ciphertext dda97ca4864cdfe06eaf70a0ec0d7191 -> same plaintext, latency 12.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> dataout stable, in_ready=0 and key_ready=0 throughout; first in_ready one cycle after the out handshake.
- Key and data offered together in IDLE: new key taken, datain not consumed (in_ready=0 that cycle). A second key offered while in ROUND is held off (key_ready=0) and the current block still decrypts with the old key.
- Assert rst_n low at round 5 of a decrypt -> out_valid=0, dataout=0, key_ready=1 asynchronously. A new block offered without a key load is never accepted (in_ready=0).
- With AES_DEC_2ROUND_EN defined, rerun C.3 -> same plaintext, latency 7.
